// File: rtl/alu16_seq.sv
// 16-bit ALU sequencer over a 4-bit combinational alu4, one nibble per cycle LSB first.
// Latency: done 4 cycles after the accepting edge; one op per 6 cycles; start ignored while busy.
module alu16_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   input  logic        cin_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        nf,
   output logic        zf,
   output logic        cf,
   output logic        ovf,
   output logic [3:0]  alusel,
   output logic [3:0]  aluin_a,
   output logic [3:0]  aluin_b,
   output logic        Cin,
   input  logic [3:0]  alu_y,
   input  logic        alu_cf
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_ADC = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_SBB = 3'b011;
   localparam logic [3:0] SEL_IDLE = 4'b0111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state;
   logic [1:0]  idx;
   logic        cy;
   logic [2:0]  op_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [11:0] work;

   logic [1:0]  idx_nx;
   logic [15:0] r_next;
   logic        arith;
   logic        ovf_next;

   // Nibble 0 of plain ADD/SUB starts the chain without carry; everything else chains.
   function automatic logic [3:0] sel_for(input logic [2:0] o, input logic first);
      logic [3:0] s;
      case (o)
         OP_ADD:  s = first ? 4'b0000 : 4'b0001;
         OP_ADC:  s = 4'b0001;
         OP_SUB:  s = first ? 4'b0010 : 4'b0011;
         OP_SBB:  s = 4'b0011;
         default: s = {2'b10, o[1:0]};
      endcase
      return s;
   endfunction

   always_comb begin
      idx_nx   = idx + 2'd1;
      r_next   = {alu_y, work};
      arith    = ~op_q[2];
      ovf_next = arith && (r_next[15] != a_q[15]) &&
                 (op_q[1] ? (a_q[15] != b_q[15]) : (a_q[15] == b_q[15]));
   end

   // ALU drive is registered: each edge loads the operands for the nibble of the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= 2'd0;
         cy      <= 1'b0;
         op_q    <= 3'd0;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         work    <= 12'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= 16'd0;
         nf      <= 1'b0;
         zf      <= 1'b0;
         cf      <= 1'b0;
         ovf     <= 1'b0;
         alusel  <= SEL_IDLE;
         aluin_a <= 4'd0;
         aluin_b <= 4'd0;
         Cin     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  busy    <= 1'b1;
                  idx     <= 2'd0;
                  cy      <= 1'b0;
                  op_q    <= op;
                  a_q     <= opa;
                  b_q     <= opb;
                  alusel  <= sel_for(op, 1'b1);
                  aluin_a <= opa[3:0];
                  aluin_b <= opb[3:0];
                  Cin     <= ((op == OP_ADC) || (op == OP_SBB)) ? cin_in : 1'b0;
               end
            end
            S_RUN: begin
               cy <= alu_cf;
               case (idx)
                  2'd0:    work[3:0]  <= alu_y;
                  2'd1:    work[7:4]  <= alu_y;
                  2'd2:    work[11:8] <= alu_y;
                  default: ;
               endcase
               if (idx == 2'd3) begin
                  state   <= S_DONE;
                  done    <= 1'b1;
                  result  <= r_next;
                  nf      <= r_next[15];
                  zf      <= (r_next == 16'd0);
                  cf      <= arith & alu_cf;
                  ovf     <= ovf_next;
                  alusel  <= SEL_IDLE;
                  aluin_a <= 4'd0;
                  aluin_b <= 4'd0;
                  Cin     <= 1'b0;
               end else begin
                  idx     <= idx_nx;
                  alusel  <= sel_for(op_q, 1'b0);
                  aluin_a <= a_q[{idx_nx, 2'b00} +: 4];
                  aluin_b <= b_q[{idx_nx, 2'b00} +: 4];
                  Cin     <= arith & alu_cf;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: 16-bit arithmetic reference model plus a nibble-level alu4 model on the ALU port.
module tb_alu16_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] opa = 16'd0;
   logic [15:0] opb = 16'd0;
   logic        cin_in = 1'b0;
   logic        busy, done, nf, zf, cf, ovf, Cin;
   logic [15:0] result;
   logic [3:0]  alusel, aluin_a, aluin_b, alu_y;
   logic        alu_cf;

   alu16_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
      .cin_in(cin_in), .busy(busy), .done(done), .result(result),
      .nf(nf), .zf(zf), .cf(cf), .ovf(ovf), .alusel(alusel),
      .aluin_a(aluin_a), .aluin_b(aluin_b), .Cin(Cin),
      .alu_y(alu_y), .alu_cf(alu_cf)
   );

   always #5 clk = ~clk;

   // Combinational alu4: carry out for add, borrow out for subtract.
   always_comb begin
      logic [4:0] t;
      t      = 5'd0;
      alu_y  = 4'd0;
      alu_cf = 1'b0;
      case (alusel)
         4'b0000: begin t = {1'b0, aluin_a} + {1'b0, aluin_b}; alu_y = t[3:0]; alu_cf = t[4]; end
         4'b0001: begin t = {1'b0, aluin_a} + {1'b0, aluin_b} + {4'd0, Cin}; alu_y = t[3:0]; alu_cf = t[4]; end
         4'b0010: begin t = {1'b0, aluin_a} - {1'b0, aluin_b}; alu_y = t[3:0]; alu_cf = t[4]; end
         4'b0011: begin t = {1'b0, aluin_a} - {1'b0, aluin_b} - {4'd0, Cin}; alu_y = t[3:0]; alu_cf = t[4]; end
         4'b1000: alu_y = aluin_a | aluin_b;
         4'b1001: alu_y = aluin_a & aluin_b;
         4'b1010: alu_y = aluin_a ^ aluin_b;
         4'b1011: alu_y = ~aluin_a;
         default: ;
      endcase
   end

   typedef struct {
      logic [15:0] r;
      logic [3:0]  flags;   // {nf, zf, cf, ovf}
      logic [51:0] drv;     // per nibble {alusel, aluin_a, aluin_b, Cin}
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [51:0] seen;
   int          nseen = 0;
   logic        prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic ci);
      exp_t e;
      int   ai, bi, c0, s, m, cn;
      logic [3:0] sel;
      ai = int'(a);
      bi = int'(b);
      c0 = ((o == 3'd1) || (o == 3'd3)) ? int'(ci) : 0;
      e.acc = 0;
      case (o)
         3'd0, 3'd1: begin
            s = ai + bi + c0;
            e.r = s[15:0];
            e.flags[1] = s[16];
            e.flags[0] = (a[15] == b[15]) && (e.r[15] != a[15]);
         end
         3'd2, 3'd3: begin
            s = ai - bi - c0;
            e.r = s[15:0];
            e.flags[1] = (ai < bi + c0);
            e.flags[0] = (a[15] != b[15]) && (e.r[15] != a[15]);
         end
         3'd4: begin e.r = a | b; e.flags[1:0] = 2'b00; end
         3'd5: begin e.r = a & b; e.flags[1:0] = 2'b00; end
         3'd6: begin e.r = a ^ b; e.flags[1:0] = 2'b00; end
         default: begin e.r = ~a; e.flags[1:0] = 2'b00; end
      endcase
      e.flags[3] = e.r[15];
      e.flags[2] = (e.r == 16'd0);
      for (int k = 0; k < 4; k++) begin
         case (o)
            3'd0: sel = (k == 0) ? 4'b0000 : 4'b0001;
            3'd1: sel = 4'b0001;
            3'd2: sel = (k == 0) ? 4'b0010 : 4'b0011;
            3'd3: sel = 4'b0011;
            3'd4: sel = 4'b1000;
            3'd5: sel = 4'b1001;
            3'd6: sel = 4'b1010;
            default: sel = 4'b1011;
         endcase
         // Carry into nibble k is the carry/borrow out of the low 4k bits of the full operation.
         m = (1 << (4 * k)) - 1;
         if (o[2]) cn = 0;
         else if (k == 0) cn = c0;
         else if (!o[1]) cn = ((ai & m) + (bi & m) + c0) >> (4 * k);
         else cn = ((ai & m) < ((bi & m) + c0)) ? 1 : 0;
         e.drv[k*13 +: 13] = {sel, a[k*4 +: 4], b[k*4 +: 4], cn[0]};
      end
      return e;
   endfunction

   // Monitor: collects RUN-cycle ALU drive and scores each done against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && !done) begin
            if (nseen < 4) seen[nseen*13 +: 13] = {alusel, aluin_a, aluin_b, Cin};
            nseen++;
         end else begin
            check("idle_drive", {51'd0, alusel, aluin_a, aluin_b, Cin}, 64'h0E00);
         end
         if (done) begin
            exp_t e;
            check("done_pulse", {63'd0, prev_done}, 64'd0);
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               check("latency", 64'(cyc), 64'(e.acc + 4));
               check("result", {48'd0, result}, {48'd0, e.r});
               check("flags", {60'd0, nf, zf, cf, ovf}, {60'd0, e.flags});
               check("run_cycles", 64'(nseen), 64'd4);
               check("alu_drive", {12'd0, seen}, {12'd0, e.drv});
               check("busy_in_done", {63'd0, busy}, 64'd1);
            end
            nseen = 0;
         end
         prev_done = done;
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_outs"}, {40'd0, busy, done, result, nf, zf, cf, ovf},
            {40'd0, 2'b00, 16'h0000, 4'b0000});
      check({tag, "_drive"}, {51'd0, alusel, aluin_a, aluin_b, Cin}, 64'h0E00);
   endtask

   task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input int gap, input bit lit,
                        input logic [15:0] lr, input logic [3:0] lf);
      exp_t e;
      op = o; opa = a; opb = b; cin_in = ci; start = 1'b1;
      e = model(o, a, b, ci);
      e.acc = cyc + 1;
      if (lit) begin
         e.r = lr;
         e.flags = lf;
      end
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      op = 3'($urandom); opa = 16'($urandom); opb = 16'($urandom); cin_in = 1'($urandom);
      repeat (5 + gap) @(negedge clk);
   endtask

   initial begin
      int next_ok;
      exp_t e;

      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases with hand-derived results: flags are {nf, zf, cf, ovf}.
      issue(3'd0, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b1, 16'h8000, 4'b1001);
      issue(3'd2, 16'h0000, 16'h0001, 1'b1, 0, 1'b1, 16'hFFFF, 4'b1010);
      issue(3'd1, 16'hFFFF, 16'h0000, 1'b1, 1, 1'b1, 16'h0000, 4'b0110);
      issue(3'd3, 16'h8000, 16'h0000, 1'b1, 0, 1'b1, 16'h7FFF, 4'b0001);
      issue(3'd6, 16'hA5A5, 16'h5A5A, 1'b1, 2, 1'b1, 16'hFFFF, 4'b1000);
      issue(3'd7, 16'h0F0F, 16'h1234, 1'b1, 0, 1'b1, 16'hF0F0, 4'b1000);

      for (int i = 0; i < 40; i++)
         issue(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
               int'($urandom_range(0, 2)), 1'b0, 16'd0, 4'd0);

      // start held high with operands changing every cycle: only operands at accepting edges count.
      next_ok = cyc + 1;
      for (int i = 0; i < 36; i++) begin
         op = 3'($urandom); opa = 16'($urandom); opb = 16'($urandom); cin_in = 1'($urandom);
         start = 1'b1;
         if (cyc + 1 >= next_ok) begin
            e = model(op, opa, opb, cin_in);
            e.acc = cyc + 1;
            q.push_back(e);
            next_ok = cyc + 7;
         end
         @(negedge clk);
      end
      start = 1'b0;
      while (cyc + 1 < next_ok) @(negedge clk);

      // Reset during RUN nibble 2 aborts the op without a done.
      op = 3'd0; opa = 16'h1234; opb = 16'h4321; cin_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      #1;
      nseen = 0;
      prev_done = 1'b0;
      check_reset("midrun_reset");
      repeat (2) @(negedge clk);
      check_reset("reset_hold");
      rst_n = 1'b1;
      @(negedge clk);
      issue(3'd2, 16'h8000, 16'h0001, 1'b0, 0, 1'b1, 16'h7FFF, 4'b0001);
      issue(3'd5, 16'hF0F0, 16'h3C3C, 1'b0, 0, 1'b1, 16'h3030, 4'b0000);

      for (int w = 0; w < 50 && q.size() != 0; w++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
